validador_faixa: RTL and testbench
==================================

VALIDADOR_FAIXA -- requirements
Module: validador_faixa

Interface
REQ-001 The block SHALL have parameter DIGITOS, default 3: BCD digits per distance value.
REQ-002 The block SHALL have parameter N_ACERTOS, default 4: consecutive in-range samples needed to assert acertou (range 1..255).
REQ-003 The block SHALL have parameter TIMEOUT_CICLOS, default 3_000_000: clock cycles allowed between samples before an error is flagged (60 ms at 50 MHz).
REQ-004 The block SHALL have port clock  in  1  system clock; one clock; all logic on the rising edge.
REQ-005 The block SHALL have port reset  in  1  reset; synchronous, active-high.
REQ-006 The block SHALL have port medir  in  1  level; high arms validation, low returns to idle.
REQ-007 The block SHALL have port amostra_pronto  in  1  one-cycle pulse marking medida valid.
REQ-008 The block SHALL have port medida  in  4*DIGITOS  BCD distance in cm.
REQ-009 The block SHALL have port upperL  in  4*DIGITOS  BCD upper limit, inclusive.
REQ-010 The block SHALL have port lowerL  in  4*DIGITOS  BCD lower limit, inclusive.
REQ-011 The block SHALL have port dentro  out  1  last accepted sample was in range.
REQ-012 The block SHALL have port acertou  out  1  N_ACERTOS consecutive in-range samples reached.
REQ-013 The block SHALL have port erro_timeout  out  1  sticky; sample interval exceeded.
REQ-014 The block SHALL have port contagem  out  $clog2(N_ACERTOS+1)  current consecutive in-range count.
REQ-015 The block SHALL have port db_medida  out  4*DIGITOS  last accepted sample.
REQ-016 The block SHALL have port db_estado  out  4  state code.

Function
REQ-017 The FSM SHALL use these state codes: OCIOSO=0, ESPERA=1, ACERTO=3, TIMEOUT=4.
REQ-018 OCIOSO: the block SHALL go to ESPERA when medir=1, latch upperL/lowerL, and clear the timer.
REQ-019 While the block is not in OCIOSO, it SHALL ignore changes on upperL/lowerL.
REQ-020 A sample SHALL be in range iff lowerL <= medida <= upperL, using an unsigned compare on the BCD vectors.
REQ-021 If lowerL > upperL, the block SHALL treat no sample as in range.
REQ-022 A sample containing any digit >9 SHALL be invalid: it SHALL set dentro=0 and contagem=0, and it SHALL NOT update db_medida.
REQ-023 Each amostra_pronto pulse in ESPERA or ACERTO SHALL update dentro, contagem and db_medida on the next rising edge (latency 1 cycle).
REQ-024 Each amostra_pronto pulse in ESPERA or ACERTO SHALL clear the timer.
REQ-025 An in-range sample SHALL increment contagem, saturating at N_ACERTOS.
REQ-026 An out-of-range or invalid sample SHALL set contagem to 0.
REQ-027 In ESPERA, the block SHALL go to ACERTO in the same edge on which contagem reaches N_ACERTOS.
REQ-028 acertou SHALL equal (state==ACERTO), registered.
REQ-029 The timer SHALL count cycles since the last sample while the block is in ESPERA (and in ACERTO, subject to REQ-039).
REQ-030 When the timer reaches TIMEOUT_CICLOS-1 with no amostra_pronto in that cycle, the block SHALL go to TIMEOUT, set erro_timeout=1, and set acertou=0.
REQ-031 If amostra_pronto coincides with timer expiry, the sample SHALL be processed and no timeout SHALL occur.
REQ-032 TIMEOUT SHALL be left only when medir=0 (to OCIOSO), and it SHALL ignore samples.
REQ-033 A medir=0 in any state SHALL send the block to OCIOSO on the next edge, clearing contagem, dentro, acertou, erro_timeout and the timer; db_medida SHALL be held.
REQ-034 amostra_pronto in OCIOSO SHALL be ignored.

Reset
REQ-035 reset=1 at a rising edge SHALL force OCIOSO, including mid-operation.
REQ-036 reset SHALL clear all outputs: dentro=0, acertou=0, erro_timeout=0, contagem=0, db_medida=0, db_estado=0.
REQ-037 reset SHALL take priority over medir and amostra_pronto.

Configuration
REQ-038 With VALIDADOR_TRAVA_EN defined, the block SHALL stay in ACERTO on out-of-range or invalid samples: acertou stays latched until medir=0 or reset, while contagem and dentro still update per REQ-023 to REQ-026.
REQ-039 With VALIDADOR_TRAVA_EN defined, the timer SHALL be disabled in ACERTO.
REQ-040 Without VALIDADOR_TRAVA_EN, an out-of-range or invalid sample in ACERTO SHALL cause ACERTO->ESPERA, with acertou=0 and contagem=0 on the next edge, and the timer SHALL be active in ACERTO.

Verification (DIGITOS=3, N_ACERTOS=4, TIMEOUT_CICLOS=100, limits 070/080)
REQ-041 Four samples of 075 -> contagem 1,2,3,4; acertou=1 and db_estado=3 one cycle after the 4th pulse.
REQ-042 Samples 075,075,075,100,075x4 -> contagem returns to 0 at 100; acertou rises only after the 8th sample.
REQ-043 Samples 070 and 080 -> dentro=1; samples 069 and 081 -> dentro=0; sample 0A5 -> dentro=0, contagem=0, db_medida unchanged.
REQ-044 medir=1 with no sample for 100 cycles -> erro_timeout=1 and db_estado=4; medir=0 -> db_estado=0 and erro_timeout=0 next cycle; a sample on cycle 99 prevents the timeout.
REQ-045 In ACERTO, sample 100 -> without the macro acertou=0 and db_estado=1 next cycle; with the macro acertou stays 1 and contagem=0.
REQ-046 medir drop or reset at contagem=2 -> all outputs cleared next cycle per REQ-033 or REQ-036; a limits change while armed has no effect.

Source files
------------

// File: rtl/validador_faixa.sv
`default_nettype none
// ============================================================================
// Module   : validador_faixa
// Purpose  : Range validator for BCD distance samples. While armed by medir,
//            each sample marked by amostra_pronto is compared against the
//            limits latched at arming time. N_ACERTOS consecutive in-range
//            samples raise acertou. A gap longer than TIMEOUT_CICLOS between
//            samples raises the sticky erro_timeout.
// Ports    : clock, reset           - clock and synchronous active-high reset
//            medir                  - level, high arms, low returns to idle
//            amostra_pronto, medida - sample strobe and BCD sample
//            upperL, lowerL         - BCD limits (inclusive), latched on arm
//            dentro, acertou        - last sample in range / run completed
//            erro_timeout           - sticky sample-interval error
//            contagem               - consecutive in-range count (saturating)
//            db_medida, db_estado   - last valid sample / state code
// Options  : VALIDADOR_TRAVA_EN - hold ACERTO on bad samples and freeze the
//            timer while in ACERTO.
// Revision : 1.0 - initial release
// ============================================================================
module validador_faixa #(
    parameter int DIGITOS        = 3,
    parameter int N_ACERTOS      = 4,
    parameter int TIMEOUT_CICLOS = 3_000_000
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             medir,
    input  logic                             amostra_pronto,
    input  logic [4*DIGITOS-1:0]             medida,
    input  logic [4*DIGITOS-1:0]             upperL,
    input  logic [4*DIGITOS-1:0]             lowerL,
    output logic                             dentro,
    output logic                             acertou,
    output logic                             erro_timeout,
    output logic [$clog2(N_ACERTOS+1)-1:0]   contagem,
    output logic [4*DIGITOS-1:0]             db_medida,
    output logic [3:0]                       db_estado
);

    localparam int c_dw = 4 * DIGITOS;
    localparam int c_cw = $clog2(N_ACERTOS + 1);
    localparam int c_tw = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
    localparam logic [c_cw-1:0] c_n_acertos = c_cw'(N_ACERTOS);
    localparam logic [c_tw-1:0] c_timer_max = c_tw'(TIMEOUT_CICLOS - 1);

`ifdef VALIDADOR_TRAVA_EN
    localparam bit c_trava = 1'b1;
`else
    localparam bit c_trava = 1'b0;
`endif

    typedef enum logic [3:0] {
        OCIOSO  = 4'd0,
        ESPERA  = 4'd1,
        ACERTO  = 4'd3,
        TIMEOUT = 4'd4
    } estado_t;

    estado_t          r_estado,   w_estado;
    logic [c_dw-1:0]  r_upper,    w_upper;
    logic [c_dw-1:0]  r_lower,    w_lower;
    logic [c_tw-1:0]  r_timer,    w_timer;
    logic [c_cw-1:0]  r_contagem, w_contagem;
    logic             r_dentro,   w_dentro;
    logic             r_acertou,  w_acertou;
    logic             r_erro,     w_erro;
    logic [c_dw-1:0]  r_db,       w_db;

    logic w_digitos_ok;
    logic w_na_faixa;

    // Any nibble above 9 makes the sample unusable.
    always_comb begin
        w_digitos_ok = 1'b1;
        for (int d = 0; d < DIGITOS; d++) begin
            if (medida[4*d +: 4] > 4'd9) begin
                w_digitos_ok = 1'b0;
            end
        end
    end

    // Plain unsigned compare works on BCD because digit weights are ordered.
    // Inverted limits can never be satisfied, the explicit check documents it.
    assign w_na_faixa = w_digitos_ok && (r_lower <= r_upper) &&
                        (medida >= r_lower) && (medida <= r_upper);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado <= OCIOSO;
        end else begin
            r_estado <= w_estado;
        end
    end

    always_comb begin
        w_estado   = r_estado;
        w_upper    = r_upper;
        w_lower    = r_lower;
        w_timer    = r_timer;
        w_contagem = r_contagem;
        w_dentro   = r_dentro;
        w_erro     = r_erro;
        w_db       = r_db;

        if (!medir) begin
            w_estado   = OCIOSO;
            w_timer    = '0;
            w_contagem = '0;
            w_dentro   = 1'b0;
            w_erro     = 1'b0;
        end else begin
            case (r_estado)
                OCIOSO: begin
                    w_estado = ESPERA;
                    w_upper  = upperL;
                    w_lower  = lowerL;
                    w_timer  = '0;
                end
                ESPERA, ACERTO: begin
                    if (amostra_pronto) begin
                        // A sample always wins over a coincident timer expiry.
                        w_timer  = '0;
                        w_dentro = w_na_faixa;
                        if (w_digitos_ok) begin
                            w_db = medida;
                        end
                        if (w_na_faixa) begin
                            w_contagem = (r_contagem == c_n_acertos) ? c_n_acertos
                                                                     : r_contagem + 1'b1;
                        end else begin
                            w_contagem = '0;
                        end
                        if (r_estado == ESPERA) begin
                            if (w_na_faixa && (w_contagem == c_n_acertos)) begin
                                w_estado = ACERTO;
                            end
                        end else if (!w_na_faixa && !c_trava) begin
                            w_estado = ESPERA;
                        end
                    end else if ((r_estado == ESPERA) || !c_trava) begin
                        if (r_timer == c_timer_max) begin
                            w_estado = TIMEOUT;
                            w_erro   = 1'b1;
                        end else begin
                            w_timer = r_timer + 1'b1;
                        end
                    end
                end
                TIMEOUT: begin
                    // Parked until medir drops; samples are ignored.
                end
                default: begin
                    w_estado = OCIOSO;
                end
            endcase
        end

        w_acertou = (w_estado == ACERTO);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_upper    <= '0;
            r_lower    <= '0;
            r_timer    <= '0;
            r_contagem <= '0;
            r_dentro   <= 1'b0;
            r_acertou  <= 1'b0;
            r_erro     <= 1'b0;
            r_db       <= '0;
        end else begin
            r_upper    <= w_upper;
            r_lower    <= w_lower;
            r_timer    <= w_timer;
            r_contagem <= w_contagem;
            r_dentro   <= w_dentro;
            r_acertou  <= w_acertou;
            r_erro     <= w_erro;
            r_db       <= w_db;
        end
    end

    assign dentro       = r_dentro;
    assign acertou      = r_acertou;
    assign erro_timeout = r_erro;
    assign contagem     = r_contagem;
    assign db_medida    = r_db;
    assign db_estado    = r_estado;

endmodule
`default_nettype wire

// File: tb/tb_validador_faixa.sv
`default_nettype none
// ============================================================================
// Module   : tb_validador_faixa
// Purpose  : Self-checking bench for validador_faixa (DIGITOS=3, N_ACERTOS=4,
//            TIMEOUT_CICLOS=100). Directed scenarios followed by randomized
//            traffic, every cycle compared against a behavioural model.
// Options  : VALIDADOR_TRAVA_EN selects the latched-ACERTO expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_validador_faixa;

    localparam int DIGITOS        = 3;
    localparam int N_ACERTOS      = 4;
    localparam int TIMEOUT_CICLOS = 100;
`ifdef VALIDADOR_TRAVA_EN
    localparam bit TRAVA = 1'b1;
`else
    localparam bit TRAVA = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        medir;
    logic        amostra_pronto;
    logic [11:0] medida;
    logic [11:0] upperL;
    logic [11:0] lowerL;
    logic        dentro;
    logic        acertou;
    logic        erro_timeout;
    logic [2:0]  contagem;
    logic [11:0] db_medida;
    logic [3:0]  db_estado;

    int total = 0;
    int bad   = 0;

    validador_faixa #(
        .DIGITOS        (DIGITOS),
        .N_ACERTOS      (N_ACERTOS),
        .TIMEOUT_CICLOS (TIMEOUT_CICLOS)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .medir          (medir),
        .amostra_pronto (amostra_pronto),
        .medida         (medida),
        .upperL         (upperL),
        .lowerL         (lowerL),
        .dentro         (dentro),
        .acertou        (acertou),
        .erro_timeout   (erro_timeout),
        .contagem       (contagem),
        .db_medida      (db_medida),
        .db_estado      (db_estado)
    );

    always #5 clock = ~clock;

    // ---------------- reference model (spec-level, decimal arithmetic) -----
    // Mode values are the externally visible state codes.
    int          m_mode;
    int          m_idle;     // cycles spent without a sample
    int          m_cnt;
    bit          m_dentro;
    bit          m_err;
    logic [11:0] m_db;
    int          m_lo;
    int          m_hi;

    function automatic logic [11:0] bcd(input int v);
        return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic bit bcd_ok(input logic [11:0] v);
        for (int d = 0; d < 3; d++) if (v[4*d +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int bcd_val(input logic [11:0] v);
        return 100 * int'(v[11:8]) + 10 * int'(v[7:4]) + int'(v[3:0]);
    endfunction

    task automatic model_step();
        bit ok;
        bit inr;
        if (reset) begin
            m_mode = 0; m_idle = 0; m_cnt = 0; m_dentro = 0; m_err = 0; m_db = '0;
            m_lo = 0; m_hi = 0;
        end else if (!medir) begin
            m_mode = 0; m_idle = 0; m_cnt = 0; m_dentro = 0; m_err = 0;
        end else if (m_mode == 0) begin
            m_mode = 1; m_idle = 0;
            m_lo = bcd_val(lowerL); m_hi = bcd_val(upperL);
        end else if (m_mode == 4) begin
            // stuck until disarmed
        end else if (amostra_pronto) begin
            ok  = bcd_ok(medida);
            inr = ok && (m_lo <= bcd_val(medida)) && (bcd_val(medida) <= m_hi);
            m_idle   = 0;
            m_dentro = inr;
            if (ok) m_db = medida;
            m_cnt = inr ? ((m_cnt + 1 > N_ACERTOS) ? N_ACERTOS : m_cnt + 1) : 0;
            if (m_mode == 1 && m_cnt == N_ACERTOS) m_mode = 3;
            else if (m_mode == 3 && !inr && !TRAVA) m_mode = 1;
        end else if (m_mode == 1 || !TRAVA) begin
            if (m_idle == TIMEOUT_CICLOS - 1) begin
                m_mode = 4; m_err = 1;
            end else begin
                m_idle++;
            end
        end
    endtask

    // ---------------- checking -------------------------------------------
    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clock);
        #1;
        check("dentro",       int'(dentro),       int'(m_dentro));
        check("acertou",      int'(acertou),      int'(m_mode == 3));
        check("erro_timeout", int'(erro_timeout), int'(m_err));
        check("contagem",     int'(contagem),     m_cnt);
        check("db_medida",    int'(db_medida),    int'(m_db));
        check("db_estado",    int'(db_estado),    m_mode);
    endtask

    task automatic pulse(input int v);
        medida = bcd(v); amostra_pronto = 1'b1; cycle(); amostra_pronto = 1'b0;
    endtask

    task automatic pulse_raw(input logic [11:0] v);
        medida = v; amostra_pronto = 1'b1; cycle(); amostra_pronto = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic rearm();
        medir = 1'b0; cycle();
        medir = 1'b1; cycle();
    endtask

    task automatic rand_step(input int pr_pct, inout bit prev_pr);
        int v;
        int d;
        reset = ($urandom_range(0, 299) == 0);
        if (medir) medir = ($urandom_range(0, 149) != 0);
        else       medir = ($urandom_range(0, 3) == 0);
        if (!medir && $urandom_range(0, 2) == 0) begin
            if ($urandom_range(0, 1) == 0) begin
                lowerL = bcd(70); upperL = bcd(80);
            end else begin
                lowerL = bcd($urandom_range(0, 999)); upperL = bcd($urandom_range(0, 999));
            end
        end else if ($urandom_range(0, 49) == 0) begin
            lowerL = bcd($urandom_range(0, 999)); upperL = bcd($urandom_range(0, 999));
        end
        case ($urandom_range(0, 9))
            0:       v = $urandom_range(0, 999);
            default: v = $urandom_range(60, 90);
        endcase
        medida = bcd(v);
        if ($urandom_range(0, 9) == 0) begin
            d = $urandom_range(0, 2);
            medida[4*d +: 4] = 4'(10 + $urandom_range(0, 5));
        end
        amostra_pronto = !prev_pr && ($urandom_range(0, 99) < pr_pct);
        prev_pr = amostra_pronto;
        cycle();
    endtask

    initial begin
        bit prev_pr;
        reset = 1'b1; medir = 1'b0; amostra_pronto = 1'b0;
        medida = '0; lowerL = bcd(70); upperL = bcd(80);
        idle(2);
        check("rst_estado",  int'(db_estado), 0);
        check("rst_acertou", int'(acertou), 0);
        check("rst_db",      int'(db_medida), 0);
        reset = 1'b0;

        // Four in-range samples complete a run.
        medir = 1'b1; cycle();
        for (int i = 1; i <= 4; i++) begin
            pulse(75);
            check("run_cnt", int'(contagem), i);
            if (i < 4) idle(1);
        end
        check("run_acertou", int'(acertou), 1);
        check("run_estado",  int'(db_estado), 3);

        // Out-of-range sample while in ACERTO.
        pulse(100);
        check("bad_cnt",     int'(contagem), 0);
        check("bad_acertou", int'(acertou), TRAVA ? 1 : 0);
        check("bad_estado",  int'(db_estado), TRAVA ? 3 : 1);

        medir = 1'b0; cycle();
        check("drop_estado", int'(db_estado), 0);
        check("drop_cnt",    int'(contagem), 0);

        // Broken run restarts the count.
        medir = 1'b1; cycle();
        pulse(75); pulse(75); pulse(75); pulse(100);
        check("brk_cnt", int'(contagem), 0);
        pulse(75); pulse(75); pulse(75);
        check("brk_acertou_pre", int'(acertou), 0);
        pulse(75);
        check("brk_acertou", int'(acertou), 1);

        // Inclusive boundaries and invalid BCD.
        rearm();
        pulse(70); check("lo_edge", int'(dentro), 1);
        pulse(80); check("hi_edge", int'(dentro), 1);
        pulse(69); check("below",   int'(dentro), 0);
        pulse(81); check("above",   int'(dentro), 0);
        pulse(75); pulse_raw(12'h0A5);
        check("inv_dentro", int'(dentro), 0);
        check("inv_cnt",    int'(contagem), 0);
        check("inv_db",     int'(db_medida), 12'h075);

        // Timer boundary: sample on the last cycle saves it, then expiry.
        rearm();
        idle(TIMEOUT_CICLOS - 1);
        pulse(75);
        check("to_saved", int'(erro_timeout), 0);
        idle(TIMEOUT_CICLOS - 1);
        check("to_pre", int'(erro_timeout), 0);
        idle(1);
        check("to_err",    int'(erro_timeout), 1);
        check("to_estado", int'(db_estado), 4);
        pulse(75);
        check("to_ignore", int'(db_estado), 4);
        medir = 1'b0; cycle();
        check("to_clr_estado", int'(db_estado), 0);
        check("to_clr_err",    int'(erro_timeout), 0);

        // Limits changed while armed have no effect; reset mid-run.
        medir = 1'b1; cycle();
        pulse(75); pulse(75);
        lowerL = bcd(0); upperL = bcd(1);
        pulse(75);
        check("lim_hold", int'(contagem), 3);
        reset = 1'b1; cycle(); reset = 1'b0;
        check("mid_rst_estado", int'(db_estado), 0);
        check("mid_rst_db",     int'(db_medida), 0);
        check("mid_rst_cnt",    int'(contagem), 0);
        lowerL = bcd(70); upperL = bcd(80);

        // Randomized traffic: busy phases and silent phases (for timeouts).
        prev_pr = 1'b0;
        for (int ph = 0; ph < 24; ph++) begin
            int pct;
            pct = (ph % 3 == 2) ? 0 : 50;
            for (int k = 0; k < 200; k++) rand_step(pct, prev_pr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
